// File: rtl/pc_gen_pkg.sv
// Shared RISC-V fetch definitions for pc_gen: opcodes, NOP, immediate extraction
// and the 2-bit branch-history counter helpers.
package pc_gen_pkg;

  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  localparam logic [1:0]  CTR_INIT   = 2'b01;
  localparam logic [1:0]  CTR_MAX    = 2'b11;
  localparam logic [1:0]  CTR_MIN    = 2'b00;

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  // Saturating step of a 2-bit predictor counter.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken)
      return (ctr == CTR_MAX) ? CTR_MAX : ctr + 2'd1;
    else
      return (ctr == CTR_MIN) ? CTR_MIN : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/pc_gen_bht.sv
// Branch history table: array of 2-bit saturating counters with one
// combinational read port and one registered update port.
module pc_gen_bht
  import pc_gen_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int ENTRIES = 2 ** IDX_W;

  logic [1:0] ctr [ENTRIES];

  // Read sees the stored value, so a same-cycle update does not affect it.
  assign rd_taken = ctr[rd_idx][1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_INIT;
    end else if (upd_valid) begin
      ctr[upd_idx] <= ctr_next(ctr[upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Next-PC generator and IF/ID register. Branch prediction uses a BHT when
// PC_GEN_BHT_EN is defined, otherwise static backward-taken/forward-not-taken.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BHT_IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [31:0] inst,
  input  logic        is_jump,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic        is_branch,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  output logic [31:0] pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_pred_taken
);

  logic        dec_jal;
  logic        dec_jalr;
  logic        dec_br;
  logic        br_taken;
  logic        pred_taken;
  logic [31:0] next_pc;

  assign dec_jal  = is_jump & is_jal;
  assign dec_jalr = is_jump & is_jalr & ~is_jal;
  assign dec_br   = is_jump & is_branch;

`ifdef PC_GEN_BHT_EN
  pc_gen_bht #(
    .IDX_W(BHT_IDX_W)
  ) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (pc[BHT_IDX_W+1:2]),
    .rd_taken (br_taken),
    .upd_valid(upd_valid),
    .upd_idx  (upd_pc[BHT_IDX_W+1:2]),
    .upd_taken(upd_taken)
  );
`else
  // Backward branches (negative offset) predicted taken.
  assign br_taken = inst[31];
`endif

  always_comb begin
    pred_taken = 1'b0;
    next_pc    = pc + 32'd4;
    if (dec_jal) begin
      pred_taken = 1'b1;
      next_pc    = (pc + imm_j(inst)) & ~32'h3;
    end else if (dec_br && br_taken) begin
      pred_taken = 1'b1;
      next_pc    = (pc + imm_b(inst)) & ~32'h3;
    end else if (dec_jalr) begin
      // Target depends on a register value; fall through and let execute redirect.
      pred_taken = 1'b0;
      next_pc    = pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      id_valid      <= 1'b0;
      id_pc         <= 32'h0;
      id_inst       <= NOP;
      id_pred_taken <= 1'b0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      id_valid <= 1'b0;
    end else if (!stall) begin
      pc            <= next_pc;
      id_valid      <= 1'b1;
      id_pc         <= pc;
      id_inst       <= inst;
      id_pred_taken <= pred_taken;
    end
  end

endmodule
